// File: rtl/bswap_pkg.sv
// Shared types and byte-shuffle helpers for the endian-swap scheduler.
// bswap_half() is only compiled when BSWAP_SCHED_HALF_EN is defined.
package bswap_pkg;

    // Widest word supported; DW-generic helpers work on this container and a byte count.
    localparam int unsigned MaxDw    = 512;
    localparam int unsigned MaxBytes = MaxDw / 8;

    typedef logic [MaxDw-1:0] word_t;

    // Reverse the lowest nbytes bytes: byte k moves to byte nbytes-1-k.
    function automatic word_t bswap_full(input word_t w, input int unsigned nbytes);
        word_t res;
        res = '0;
        for (int unsigned k = 0; k < MaxBytes; k++) begin
            if (k < nbytes) begin
                res[k*8 +: 8] = w[(nbytes-1-k)*8 +: 8];
            end
        end
        return res;
    endfunction

`ifdef BSWAP_SCHED_HALF_EN
    // Swap the two bytes inside every 16-bit halfword of the lowest nbytes bytes.
    function automatic word_t bswap_half(input word_t w, input int unsigned nbytes);
        word_t res;
        res = '0;
        for (int unsigned h = 0; h < MaxBytes / 2; h++) begin
            if ((2*h + 1) < nbytes) begin
                res[(2*h)*8 +: 8]   = w[(2*h+1)*8 +: 8];
                res[(2*h+1)*8 +: 8] = w[(2*h)*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/bswap_sched_if.sv
// Requester/output bundle of the endian-swap scheduler.
// req_mode/out_mode exist only when BSWAP_SCHED_HALF_EN is defined.
interface bswap_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [IDW-1:0]     out_id;
    logic               busy;
`ifdef BSWAP_SCHED_HALF_EN
    logic [NREQ-1:0]    req_mode;
    logic               out_mode;
`endif

    modport master (
        output req_valid, req_data, out_ready,
`ifdef BSWAP_SCHED_HALF_EN
        output req_mode,
        input  out_mode,
`endif
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
`ifdef BSWAP_SCHED_HALF_EN
        input  req_mode,
        output out_mode,
`endif
        output req_ready, out_valid, out_data, out_id, busy
    );

endinterface

// File: rtl/bswap_rr_arb.sv
// Combinational round-robin winner search starting one past the last grant.
module bswap_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_valid_o
);

    int unsigned idx;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        // Offset NREQ wraps back to ptr itself, so it has lowest priority.
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr_i) + off) % NREQ;
            if (!any_valid_o && req_valid_i[idx]) begin
                any_valid_o = 1'b1;
                winner_o    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/bswap_sched.sv
// Round-robin scheduler sharing one registered byte-reversal stage among NREQ requesters.
// Define BSWAP_SCHED_HALF_EN to add per-request halfword-swap mode (req_mode/out_mode).
module bswap_sched
    import bswap_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32
) (
    input logic          clk,
    input logic          rst_n,
    bswap_sched_if.slave bus
);

    localparam int unsigned IDW    = $clog2(NREQ);
    localparam int unsigned NBytes = DW / 8;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  data_q, data_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
`ifdef BSWAP_SCHED_HALF_EN
    logic           mode_q, mode_d;
`endif

    logic [IDW-1:0] winner;
    logic           any_valid;
    logic           slot_free;
    logic           accept;
    logic [DW-1:0]  sel_word;

    bswap_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid_i (bus.req_valid),
        .ptr_i       (ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    always_comb begin
        slot_free = (state_q == StEmpty) || bus.out_ready;
        // Gate with rst_n so nothing is handshaken while reset is held.
        accept    = rst_n && slot_free && any_valid;
        sel_word  = bus.req_data[int'(winner) * DW +: DW];

        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[winner] = 1'b1;
        end

        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
`ifdef BSWAP_SCHED_HALF_EN
        mode_d  = mode_q;
`endif

        if (accept) begin
            state_d = StFull;
            id_d    = winner;
            ptr_d   = winner;
`ifdef BSWAP_SCHED_HALF_EN
            mode_d  = bus.req_mode[winner];
            data_d  = bus.req_mode[winner] ? DW'(bswap_half(word_t'(sel_word), NBytes))
                                           : DW'(bswap_full(word_t'(sel_word), NBytes));
`else
            data_d  = DW'(bswap_full(word_t'(sel_word), NBytes));
`endif
        end else if (slot_free) begin
            // Drain only: payload registers keep their last values.
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= IDW'(NREQ - 1);
`ifdef BSWAP_SCHED_HALF_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
`ifdef BSWAP_SCHED_HALF_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign bus.out_valid = (state_q == StFull);
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.busy      = (state_q == StFull) || (|bus.req_valid);
`ifdef BSWAP_SCHED_HALF_EN
    assign bus.out_mode  = mode_q;
`endif

endmodule

// File: tb/tb_bswap_sched.sv
// Directed self-checking bench for bswap_sched (NREQ=4, DW=32).
// Halfword-mode vectors run when BSWAP_SCHED_HALF_EN is defined.
module tb_bswap_sched;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bswap_sched_if #(.NREQ(4), .DW(32)) bif ();

    bswap_sched #(
        .NREQ (4),
        .DW   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        bif.req_data[i*32 +: 32] = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.req_valid = 4'b1111;
        bif.out_ready = 1'b1;
        tick();
        tick();
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
        n_vec++; if (bif.out_data !== 32'h0) begin n_err++;
            $display("FAIL reset_out_data: got %h want 00000000", bif.out_data); end
        n_vec++; if (bif.out_id !== 2'd0) begin n_err++;
            $display("FAIL reset_out_id: got %0d want 0", bif.out_id); end
        n_vec++; if (bif.req_ready !== 4'b0000) begin n_err++;
            $display("FAIL reset_req_ready: got %b want 0000", bif.req_ready); end
        n_vec++; if (bif.busy !== 1'b1) begin n_err++;
            $display("FAIL reset_busy_valid: got %b want 1", bif.busy); end
        bif.req_valid = 4'b0000;
        #1;
        n_vec++; if (bif.busy !== 1'b0) begin n_err++;
            $display("FAIL reset_busy_idle: got %b want 0", bif.busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_word(2, 32'h11223344);
        bif.req_valid = 4'b0100;
        #1;
        n_vec++; if (bif.req_ready !== 4'b0100) begin n_err++;
            $display("FAIL single_ready: got %b want 0100", bif.req_ready); end
        tick();
        bif.req_valid = 4'b0000;
        n_vec++; if (bif.out_valid !== 1'b1) begin n_err++;
            $display("FAIL single_out_valid: got %b want 1", bif.out_valid); end
        n_vec++; if (bif.out_data !== 32'h44332211) begin n_err++;
            $display("FAIL single_out_data: got %h want 44332211", bif.out_data); end
        n_vec++; if (bif.out_id !== 2'd2) begin n_err++;
            $display("FAIL single_out_id: got %0d want 2", bif.out_id); end
        tick();
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++;
            $display("FAIL drain_out_valid: got %b want 0", bif.out_valid); end
        n_vec++; if (bif.out_data !== 32'h44332211) begin n_err++;
            $display("FAIL drain_hold_data: got %h want 44332211", bif.out_data); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_d;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_word(i, 32'(i));
        bif.out_ready = 1'b1;
        bif.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_d = 32'(k % 4) << 24;
            n_vec++; if (bif.out_valid !== 1'b1) begin n_err++;
                $display("FAIL rr_valid[%0d]: got %b want 1", k, bif.out_valid); end
            n_vec++; if (bif.out_id !== 2'(k % 4)) begin n_err++;
                $display("FAIL rr_id[%0d]: got %0d want %0d", k, bif.out_id, k % 4); end
            n_vec++; if (bif.out_data !== exp_d) begin n_err++;
                $display("FAIL rr_data[%0d]: got %h want %h", k, bif.out_data, exp_d); end
        end
    endtask

    // Continues from round-robin: requester 1 is held in the output slot.
    task automatic test_backpressure();
        bif.out_ready = 1'b0;
        bif.req_valid = 4'b1111;
        #1;
        n_vec++; if (bif.req_ready !== 4'b0000) begin n_err++;
            $display("FAIL bp_ready_first: got %b want 0000", bif.req_ready); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if (bif.req_ready !== 4'b0000) begin n_err++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", c, bif.req_ready); end
            n_vec++; if (bif.out_id !== 2'd1 || bif.out_valid !== 1'b1) begin n_err++;
                $display("FAIL bp_id[%0d]: got id %0d valid %b want id 1 valid 1",
                         c, bif.out_id, bif.out_valid); end
            n_vec++; if (bif.out_data !== 32'h01000000) begin n_err++;
                $display("FAIL bp_data[%0d]: got %h want 01000000", c, bif.out_data); end
        end
        bif.out_ready = 1'b1;
        #1;
        n_vec++; if (bif.req_ready !== 4'b0100) begin n_err++;
            $display("FAIL bp_release_ready: got %b want 0100", bif.req_ready); end
        tick();
        n_vec++; if (bif.out_id !== 2'd2) begin n_err++;
            $display("FAIL bp_release_id: got %0d want 2", bif.out_id); end
        n_vec++; if (bif.out_data !== 32'h02000000) begin n_err++;
            $display("FAIL bp_release_data: got %h want 02000000", bif.out_data); end
        bif.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_idle_gap();
        bif.req_valid = 4'b0010;
        tick();
        bif.req_valid = 4'b0000;
        n_vec++; if (bif.out_id !== 2'd1) begin n_err++;
            $display("FAIL gap_first_id: got %0d want 1", bif.out_id); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (bif.out_valid !== 1'b0) begin n_err++;
                $display("FAIL gap_idle[%0d]: got %b want 0", c, bif.out_valid); end
        end
        bif.req_valid = 4'b0101;
        #1;
        n_vec++; if (bif.req_ready !== 4'b0100) begin n_err++;
            $display("FAIL gap_ready: got %b want 0100", bif.req_ready); end
        tick();
        n_vec++; if (bif.out_id !== 2'd2) begin n_err++;
            $display("FAIL gap_grant_a: got %0d want 2", bif.out_id); end
        tick();
        n_vec++; if (bif.out_id !== 2'd0) begin n_err++;
            $display("FAIL gap_grant_b: got %0d want 0", bif.out_id); end
        bif.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        set_word(2, 32'hDEADBEEF);
        bif.req_valid = 4'b0100;
        tick();
        bif.req_valid = 4'b0000;
        bif.out_ready = 1'b0;
        tick();
        n_vec++; if (bif.out_valid !== 1'b1 || bif.out_data !== 32'hEFBEADDE) begin n_err++;
            $display("FAIL mid_held: got valid %b data %h want valid 1 data efbeadde",
                     bif.out_valid, bif.out_data); end
        rst_n = 1'b0;
        bif.req_valid = 4'b1111;
        tick();
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++;
            $display("FAIL mid_valid: got %b want 0", bif.out_valid); end
        n_vec++; if (bif.out_data !== 32'h0) begin n_err++;
            $display("FAIL mid_data: got %h want 00000000", bif.out_data); end
        n_vec++; if (bif.req_ready !== 4'b0000) begin n_err++;
            $display("FAIL mid_ready_in_reset: got %b want 0000", bif.req_ready); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (bif.req_ready !== 4'b0001) begin n_err++;
            $display("FAIL mid_first_ready: got %b want 0001", bif.req_ready); end
        bif.out_ready = 1'b1;
        tick();
        n_vec++; if (bif.out_id !== 2'd0 || bif.out_valid !== 1'b1) begin n_err++;
            $display("FAIL mid_first_grant: got id %0d valid %b want id 0 valid 1",
                     bif.out_id, bif.out_valid); end
        bif.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_mode();
        set_word(0, 32'hAABBCCDD);
        bif.req_valid = 4'b0001;
`ifdef BSWAP_SCHED_HALF_EN
        bif.req_mode = 4'b0001;
        tick();
        bif.req_mode = 4'b0000;
        n_vec++; if (bif.out_data !== 32'hBBAADDCC) begin n_err++;
            $display("FAIL half_data: got %h want bbaaddcc", bif.out_data); end
        n_vec++; if (bif.out_mode !== 1'b1) begin n_err++;
            $display("FAIL half_mode: got %b want 1", bif.out_mode); end
        tick();
        n_vec++; if (bif.out_mode !== 1'b0) begin n_err++;
            $display("FAIL full_mode: got %b want 0", bif.out_mode); end
`else
        tick();
`endif
        bif.req_valid = 4'b0000;
        n_vec++; if (bif.out_data !== 32'hDDCCBBAA) begin n_err++;
            $display("FAIL full_data: got %h want ddccbbaa", bif.out_data); end
        tick();
        n_vec++; if (bif.busy !== 1'b0 || bif.out_valid !== 1'b0) begin n_err++;
            $display("FAIL final_idle: got busy %b valid %b want 0 0",
                     bif.busy, bif.out_valid); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bif.req_valid = '0;
        bif.req_data  = '0;
        bif.out_ready = 1'b0;
`ifdef BSWAP_SCHED_HALF_EN
        bif.req_mode  = '0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_idle_gap();
        test_reset_mid();
        test_mode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
